// File: rtl/axi_eth_txc_gen_pkg.sv
// Shared definitions for the TX control-packet generator: txc word layout,
// checksum-control encoding and FSM state encoding.
package axi_eth_txc_gen_pkg;

  localparam logic [31:0] C_TXC_FLAG_DEF = 32'hA000_0000;

  localparam logic [1:0]  CSCNTRL_NONE    = 2'b00;
  localparam logic [1:0]  CSCNTRL_PARTIAL = 2'b01;

  localparam int          TXC_WORDS    = 6;
  localparam logic [2:0]  TXC_LAST_IDX = 3'(TXC_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTRL = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/axi_eth_txc_gen_keep_len.sv
// Combinational tkeep checker: byte popcount, all-ones flag and
// low-aligned contiguity (2^n-1, n=1..8) flag for one 8-bit keep.
module axi_eth_keep_len (
  input  logic [7:0] keep_i,
  output logic [3:0] popcnt_o,
  output logic       full_o,
  output logic       contig_o
);

  logic [7:0] keep_inc;

  always_comb begin
    popcnt_o = 4'd0;
    for (int b = 0; b < 8; b++) begin
      popcnt_o = popcnt_o + {3'd0, keep_i[b]};
    end
  end

  // keep+1 clears every low-aligned run of ones, so the AND is zero only for 2^n-1
  assign keep_inc = 8'(keep_i + 8'd1);
  assign full_o   = (keep_i == 8'hFF);
  assign contig_o = (keep_i != 8'h00) && ((keep_i & keep_inc) == 8'h00);

endmodule

// File: rtl/axi_eth_txc_gen.sv
// Splits each MM2S frame into a 6-word txc control packet followed by the
// frame data on txd; tracks frame count, last frame length and keep errors.
module axi_eth_txc_gen
  import axi_eth_txc_gen_pkg::*;
#(
  parameter logic [31:0] C_TXC_FLAG = C_TXC_FLAG_DEF
) (
  input  logic        mm2s_clk,
  input  logic        mm2s_resetn,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic        csum_en,
  input  logic [15:0] csum_begin,
  input  logic [15:0] csum_insert,
  input  logic [15:0] csum_init,
  output logic [31:0] txc_tdata,
  output logic [3:0]  txc_tkeep,
  output logic        txc_tvalid,
  output logic        txc_tlast,
  input  logic        txc_tready,
  output logic [63:0] txd_tdata,
  output logic [7:0]  txd_tkeep,
  output logic        txd_tvalid,
  output logic        txd_tlast,
  input  logic        txd_tready,
  output logic [31:0] tx_frame_cnt,
  output logic [15:0] tx_last_len,
  output logic        keep_err
);

  state_e      state_q, state_d;
  logic [2:0]  wi_q, wi_d;
  logic        en_q, en_d;
  logic [15:0] beg_q, beg_d, ins_q, ins_d, init_q, init_d;
  logic [15:0] len_q, len_d, last_len_q, last_len_d;
  logic [31:0] cnt_q, cnt_d;
  logic        kerr_q, kerr_d;

  logic [3:0]  popcnt;
  logic        keep_full, keep_contig;
  logic        xfer;
  logic [16:0] len_sum;
  logic [15:0] len_sat;

  axi_eth_keep_len u_keep_len (
    .keep_i   (s_tkeep),
    .popcnt_o (popcnt),
    .full_o   (keep_full),
    .contig_o (keep_contig)
  );

  assign xfer    = (state_q == ST_DATA) && s_tvalid && txd_tready;
  assign len_sum = {1'b0, len_q} + {13'd0, popcnt};
  assign len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
    if (!mm2s_resetn) begin
      state_q    <= ST_IDLE;
      wi_q       <= 3'd0;
      en_q       <= 1'b0;
      beg_q      <= 16'd0;
      ins_q      <= 16'd0;
      init_q     <= 16'd0;
      len_q      <= 16'd0;
      last_len_q <= 16'd0;
      cnt_q      <= 32'd0;
      kerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wi_q       <= wi_d;
      en_q       <= en_d;
      beg_q      <= beg_d;
      ins_q      <= ins_d;
      init_q     <= init_d;
      len_q      <= len_d;
      last_len_q <= last_len_d;
      cnt_q      <= cnt_d;
      kerr_q     <= kerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wi_d       = wi_q;
    en_d       = en_q;
    beg_d      = beg_q;
    ins_d      = ins_q;
    init_d     = init_q;
    len_d      = len_q;
    last_len_d = last_len_q;
    cnt_d      = cnt_q;
    kerr_d     = kerr_q;
    case (state_q)
      ST_IDLE: begin
        if (s_tvalid) begin
          state_d = ST_CTRL;
          wi_d    = 3'd0;
          en_d    = csum_en;
          beg_d   = csum_begin;
          ins_d   = csum_insert;
          init_d  = csum_init;
          len_d   = 16'd0;
        end
      end
      ST_CTRL: begin
        if (txc_tready) begin
          if (wi_q == TXC_LAST_IDX) begin
            state_d = ST_DATA;
            wi_d    = 3'd0;
          end else begin
            wi_d = wi_q + 3'd1;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          len_d = len_sat;
          if ((!s_tlast && !keep_full) || (s_tlast && !keep_contig)) begin
            kerr_d = 1'b1;
          end
          if (s_tlast) begin
            cnt_d      = cnt_q + 32'd1;
            last_len_d = len_sat;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready   = 1'b0;
    txc_tdata  = 32'd0;
    txc_tkeep  = 4'h0;
    txc_tvalid = 1'b0;
    txc_tlast  = 1'b0;
    txd_tdata  = 64'd0;
    txd_tkeep  = 8'h00;
    txd_tvalid = 1'b0;
    txd_tlast  = 1'b0;
    case (state_q)
      ST_CTRL: begin
        txc_tvalid = 1'b1;
        txc_tkeep  = 4'hF;
        txc_tlast  = (wi_q == TXC_LAST_IDX);
        case (wi_q)
          3'd0:    txc_tdata = C_TXC_FLAG;
          3'd1:    txc_tdata = {29'd0, (en_q ? CSCNTRL_PARTIAL : CSCNTRL_NONE), 1'b0};
          3'd2:    txc_tdata = {beg_q, ins_q};
          3'd3:    txc_tdata = {16'd0, init_q};
          default: txc_tdata = 32'd0;
        endcase
      end
      ST_DATA: begin
        txd_tdata  = s_tdata;
        txd_tkeep  = s_tkeep;
        txd_tlast  = s_tlast;
        txd_tvalid = s_tvalid;
        s_tready   = txd_tready;
      end
      default: ;
    endcase
  end

  assign tx_frame_cnt = cnt_q;
  assign tx_last_len  = last_len_q;
  assign keep_err     = kerr_q;

endmodule
